// File: rtl/softplus_pkg.sv
// Package shared by the softplus segment scheduler and its comparator.
//
// Contents:
//   DEF_N, DEF_Q, DEF_SEG_W : default word width, fractional bits, segment index width
//   NSEG                    : segment count for the default index width
//   SIGN_BIT, ONE_Q         : sign-magnitude format constants for the default format
//   state_t                 : scheduler FSM state encoding (IDLE/SEARCH/DONE)
//   nseg_of()               : segment count for an arbitrary index width
package softplus_pkg;

  localparam int DEF_N     = 16;
  localparam int DEF_Q     = 12;
  localparam int DEF_SEG_W = 3;

  localparam int NSEG      = 1 << DEF_SEG_W;
  localparam int SIGN_BIT  = DEF_N - 1;
  localparam int ONE_Q     = 1 << DEF_Q;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int nseg_of(input int seg_w);
    return 1 << seg_w;
  endfunction

endpackage

// File: rtl/sm_gt_cmp.sv
// Sign-magnitude "strictly greater than" comparator.
//
// Ordering: a positive word beats a negative word; among positives the larger
// magnitude wins; among negatives the smaller magnitude wins; equal words are
// not greater. Because the sign bit decides first, -0 (sign set, magnitude 0)
// orders below +0.
//
// Parameters:
//   N : word width (bit N-1 is the sign)
//   Q : fractional bits; magnitude is compared integer part first, then fraction
//
// Ports:
//   a  in  N  left operand
//   b  in  N  right operand
//   gt out 1  1 when a > b under the ordering above
module sm_gt_cmp
  import softplus_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int Q = DEF_Q
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt
);

  localparam int INT_W = N - 1 - Q;

  logic             sign_a;
  logic             sign_b;
  logic [INT_W-1:0] int_a;
  logic [INT_W-1:0] int_b;
  logic [Q-1:0]     frac_a;
  logic [Q-1:0]     frac_b;
  logic             mag_gt;
  logic             mag_lt;

  always_comb begin
    sign_a = a[N-1];
    sign_b = b[N-1];
    int_a  = a[N-2:Q];
    int_b  = b[N-2:Q];
    frac_a = a[Q-1:0];
    frac_b = b[Q-1:0];

    // Splitting at the binary point gives the same result as a flat
    // magnitude compare; the fraction only matters on an integer tie.
    mag_gt = (int_a > int_b) || ((int_a == int_b) && (frac_a > frac_b));
    mag_lt = (int_a < int_b) || ((int_a == int_b) && (frac_a < frac_b));

    if (sign_a != sign_b) begin
      gt = ~sign_a;
    end else if (!sign_a) begin
      gt = mag_gt;
    end else begin
      gt = mag_lt;
    end
  end

endmodule

// File: rtl/softplus_seg_scheduler.sv
// Binary-search segment locator for the piecewise softplus unit.
//
// One shared sign-magnitude comparator is stepped through a programmable
// breakpoint table bp[1..NSEG-1], one probe per cycle, MSB of the segment
// index first. The result is the largest i with x > bp[i] (0 if none).
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// steady until that edge; ready may be asserted independently of valid.
// in_ready is high only in IDLE; out_valid/out_seg are held in DONE until
// out_ready takes them.
//
// Optional feature (macro SEGSCHED_XPASS_EN): adds output out_x carrying the
// captured sample alongside out_valid so the MAC stage receives x aligned
// with its segment. Without the macro the port and register do not exist.
//
// Parameters:
//   N     : word width, sign-magnitude
//   Q     : fractional bits
//   SEG_W : segment index width (NSEG = 2**SEG_W)
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      input sample valid
//   in_ready   out  1      sample can be accepted (IDLE only)
//   in_x       in   N      input sample
//   out_valid  out  1      segment result valid
//   out_ready  in   1      downstream accepts result
//   out_seg    out  SEG_W  segment index
//   out_x      out  N      captured sample (SEGSCHED_XPASS_EN only)
//   cfg_we     in   1      breakpoint write strobe
//   cfg_addr   in   SEG_W  breakpoint index; address 0 is ignored
//   cfg_data   in   N      breakpoint value
//   cfg_busy   out  1      high outside IDLE; writes are dropped while high
module softplus_seg_scheduler
  import softplus_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int Q     = DEF_Q,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEG_W-1:0] out_seg,
`ifdef SEGSCHED_XPASS_EN
  output logic [N-1:0]     out_x,
`endif
  input  logic             cfg_we,
  input  logic [SEG_W-1:0] cfg_addr,
  input  logic [N-1:0]     cfg_data,
  output logic             cfg_busy
);

  localparam int NUM_SEG = nseg_of(SEG_W);
  localparam int BIT_W   = (SEG_W > 1) ? $clog2(SEG_W) : 1;

  state_t           state;
  logic [N-1:0]     x_q;
  logic [SEG_W-1:0] idx_q;
  logic [BIT_W-1:0] bit_q;

  // Entry 0 is never probed (every probe has its current bit set); it is
  // kept so the table can be indexed directly by segment number.
  logic [N-1:0]     bp_q [NUM_SEG];

  logic [SEG_W-1:0] probe;
  logic [N-1:0]     bp_probe;
  logic             probe_gt;
  logic [SEG_W-1:0] idx_next;

  // Probe point for this cycle: the bits already decided plus the bit under test.
  always_comb begin
    probe        = idx_q;
    probe[bit_q] = 1'b1;
    bp_probe     = bp_q[probe];
  end

  sm_gt_cmp #(
    .N (N),
    .Q (Q)
  ) u_gt (
    .a  (x_q),
    .b  (bp_probe),
    .gt (probe_gt)
  );

  // Keep the tested bit only if x lies above that breakpoint.
  always_comb begin
    idx_next = probe_gt ? probe : idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      idx_q     <= '0;
      bit_q     <= '0;
      in_ready  <= 1'b1;
      cfg_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_seg   <= '0;
`ifdef SEGSCHED_XPASS_EN
      out_x     <= '0;
`endif
      for (int i = 0; i < NUM_SEG; i++) begin
        bp_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write on the accepting edge lands before the first probe
          // reads the table on the following edge.
          if (cfg_we && (cfg_addr != '0)) begin
            bp_q[cfg_addr] <= cfg_data;
          end
          if (in_valid) begin
            x_q      <= in_x;
            idx_q    <= '0;
            bit_q    <= BIT_W'(SEG_W - 1);
            in_ready <= 1'b0;
            cfg_busy <= 1'b1;
            state    <= SEARCH;
          end
        end

        SEARCH: begin
          idx_q <= idx_next;
          if (bit_q == '0) begin
            out_valid <= 1'b1;
            out_seg   <= idx_next;
`ifdef SEGSCHED_XPASS_EN
            out_x     <= x_q;
`endif
            state     <= DONE;
          end else begin
            bit_q <= bit_q - BIT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            cfg_busy  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          cfg_busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softplus_seg_scheduler.sv
// Directed testbench for softplus_seg_scheduler (N=16, Q=12, SEG_W=3).
// Breakpoint table used by most tests: bp[1..7] = -3,-2,-1,+0,+1,+2,+3.
// Build with SEGSCHED_XPASS_EN defined to also check out_x.
module tb_softplus_seg_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_seg;
`ifdef SEGSCHED_XPASS_EN
  logic [15:0] out_x;
`endif
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_busy;

  int n_checks = 0;
  int n_fail   = 0;

  softplus_seg_scheduler #(
    .N     (16),
    .Q     (12),
    .SEG_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seg   (out_seg),
`ifdef SEGSCHED_XPASS_EN
    .out_x     (out_x),
`endif
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic load_table();
    cfg_write(3'd1, 16'hB000);
    cfg_write(3'd2, 16'hA000);
    cfg_write(3'd3, 16'h9000);
    cfg_write(3'd4, 16'h0000);
    cfg_write(3'd5, 16'h1000);
    cfg_write(3'd6, 16'h2000);
    cfg_write(3'd7, 16'h3000);
  endtask

  // Waits (bounded) for out_valid; lat counts negedges since the accept edge.
  task automatic wait_result(input int lat_start, output logic [2:0] seg,
                             output int lat, output bit ok, output logic [15:0] xo);
    ok  = 1'b0;
    lat = lat_start;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    seg = out_seg;
`ifdef SEGSCHED_XPASS_EN
    xo = out_x;
`else
    xo = 16'h0000;
`endif
  endtask

  task automatic send_and_wait(input logic [15:0] x, output logic [2:0] seg,
                               output int lat, output bit ok, output logic [15:0] xo);
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(0, seg, lat, ok, xo);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_seg, in_ready, cfg_busy} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b seg=%0d rdy=%b busy=%b, want v=0 seg=0 rdy=1 busy=0",
               out_valid, out_seg, in_ready, cfg_busy);
    end
`ifdef SEGSCHED_XPASS_EN
    n_checks++;
    if (out_x !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out_x: got %h want 0000", out_x);
    end
`endif
  endtask

  task automatic test_latency();
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    load_table();
    send_and_wait(16'h1800, seg, lat, ok, xo);
    n_checks++;
    if (!ok || lat !== 4) begin
      n_fail++;
      $display("FAIL latency: got ok=%b cycles=%0d, want ok=1 cycles=4", ok, lat);
    end
    n_checks++;
    if (seg !== 3'd5) begin
      n_fail++;
      $display("FAIL seg_x1800: got %0d want 5", seg);
    end
`ifdef SEGSCHED_XPASS_EN
    n_checks++;
    if (xo !== 16'h1800) begin
      n_fail++;
      $display("FAIL out_x_x1800: got %h want 1800", xo);
    end
`endif
  endtask

  task automatic test_segments();
    logic [15:0] vec_x   [6] = '{16'h1000, 16'h0000, 16'h8000, 16'hC000, 16'h7FFF, 16'h9800};
    logic [2:0]  vec_seg [6] = '{3'd4,     3'd3,     3'd3,     3'd0,     3'd7,     3'd2};
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    for (int i = 0; i < 6; i++) begin
      send_and_wait(vec_x[i], seg, lat, ok, xo);
      n_checks++;
      if (!ok || seg !== vec_seg[i]) begin
        n_fail++;
        $display("FAIL seg_x%h: got ok=%b seg=%0d, want ok=1 seg=%0d", vec_x[i], ok, seg, vec_seg[i]);
      end
`ifdef SEGSCHED_XPASS_EN
      n_checks++;
      if (xo !== vec_x[i]) begin
        n_fail++;
        $display("FAIL out_x_x%h: got %h want %h", vec_x[i], xo, vec_x[i]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    out_ready = 1'b0;
    send_and_wait(16'h9800, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd2) begin
      n_fail++;
      $display("FAIL bp_first_result: got ok=%b seg=%0d, want ok=1 seg=2", ok, seg);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_seg, in_ready, cfg_busy} !== {1'b1, 3'd2, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b seg=%0d rdy=%b busy=%b, want v=1 seg=2 rdy=0 busy=1",
                 i, out_valid, out_seg, in_ready, cfg_busy);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, cfg_busy} !== {1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy=%b busy=%b, want v=0 rdy=1 busy=0",
               out_valid, in_ready, cfg_busy);
    end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        hits.push_back(n);
        n_checks++;
        if (out_seg !== 3'd3) begin
          n_fail++;
          $display("FAIL b2b_seg_at_%0d: got %0d want 3", n, out_seg);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (hits.size() !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results want 4", hits.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (hits[i] - hits[i-1] !== 5) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles want 5", i, hits[i] - hits[i-1]);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_cfg_drop();
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h1800;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_search: got %b want 1", cfg_busy);
    end
    cfg_we   = 1'b1;
    cfg_addr = 3'd4;
    cfg_data = 16'h7000;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    wait_result(1, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd5) begin
      n_fail++;
      $display("FAIL cfg_drop_current: got ok=%b seg=%0d, want ok=1 seg=5", ok, seg);
    end
    send_and_wait(16'h1800, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd5) begin
      n_fail++;
      $display("FAIL cfg_drop_table: got ok=%b seg=%0d, want ok=1 seg=5", ok, seg);
    end
  endtask

  task automatic test_cfg_same_edge();
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h1800;
    cfg_we   = 1'b1;
    cfg_addr = 3'd4;
    cfg_data = 16'h7000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    wait_result(0, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd3 || lat !== 4) begin
      n_fail++;
      $display("FAIL cfg_same_edge: got ok=%b seg=%0d cycles=%0d, want ok=1 seg=3 cycles=4",
               ok, seg, lat);
    end
  endtask

  task automatic test_reset_mid_search();
    logic [2:0]  seg;
    int          lat;
    bit          ok;
    logic [15:0] xo;
    int          stray;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 16'h1800;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_seg, in_ready, cfg_busy} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_search: got v=%b seg=%0d rdy=%b busy=%b, want v=0 seg=0 rdy=1 busy=0",
               out_valid, out_seg, in_ready, cfg_busy);
    end
    stray = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL rst_no_stray_result: got %0d valid cycles want 0", stray);
    end
    send_and_wait(16'h0001, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd7) begin
      n_fail++;
      $display("FAIL rst_table_pos: got ok=%b seg=%0d, want ok=1 seg=7", ok, seg);
    end
    send_and_wait(16'h8001, seg, lat, ok, xo);
    n_checks++;
    if (!ok || seg !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_table_neg: got ok=%b seg=%0d, want ok=1 seg=0", ok, seg);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 16'h0000;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_data  = 16'h0000;

    test_reset();
    test_latency();
    test_segments();
    test_backpressure();
    test_back_to_back();
    test_cfg_drop();
    test_cfg_same_edge();
    test_reset_mid_search();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
